// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side checker for the XNOR Fibonacci LFSR pattern generator.
// The history register always shifts in the received bit, so the checker
// self-synchronises to any valid stream. Once the history has been filled,
// each incoming bit is compared with the bit predicted from the history.
// After LOCK_CNT consecutive correct predictions the checker declares lock.
// While locked it pulses o_error for each wrong bit and keeps saturating bit
// and error counters. It drops back to hunting when LOSS_THR errors land
// inside one LOSS_WIN-bit window.

module prbs_checker #(
    parameter int NUM_BITS = 32,
    parameter int LOCK_CNT = 64,
    parameter int LOSS_WIN = 256,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             i_bit,
    input  logic             i_clear_cnt,
    output logic             o_locked,
    output logic             o_error,
    output logic             o_lockup,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (!((NUM_BITS == 32'd8) || (NUM_BITS == 32'd16) || (NUM_BITS == 32'd32))) begin : g_bad_num_bits
            $error("prbs_checker: NUM_BITS must be 8, 16 or 32");
        end
        if (LOCK_CNT < 32'd1) begin : g_bad_lock_cnt
            $error("prbs_checker: LOCK_CNT must be at least 1");
        end
        if (LOSS_THR < 32'd1) begin : g_bad_loss_thr
            $error("prbs_checker: LOSS_THR must be at least 1");
        end
        if (CNT_W < 32'd2) begin : g_bad_cnt_w
            $error("prbs_checker: CNT_W must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tap positions. The first tap is always the LFSR length itself.
    // The chain matches the generator, so a clean stream always predicts
    // correctly.
    // ------------------------------------------------------------------
    localparam int TAP_A = NUM_BITS;
    localparam int TAP_B = (NUM_BITS == 32'd8) ? 32'd6 : (NUM_BITS == 32'd16) ? 32'd15 : 32'd22;
    localparam int TAP_C = (NUM_BITS == 32'd8) ? 32'd5 : (NUM_BITS == 32'd16) ? 32'd13 : 32'd2;
    localparam int TAP_D = (NUM_BITS == 32'd8) ? 32'd4 : (NUM_BITS == 32'd16) ? 32'd4  : 32'd1;

    // Internal counter widths and terminal values
    localparam int FILL_W = $clog2(NUM_BITS + 32'd1);
    localparam int MR_W   = $clog2(LOCK_CNT + 32'd1);
    localparam int WIN_W  = (LOSS_WIN > 32'd1) ? $clog2(LOSS_WIN) : 32'd1;
    localparam int WE_W   = $clog2(LOSS_THR + 32'd1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_BITS);
    localparam logic [MR_W-1:0]   LOCK_RUN  = MR_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WIN - 32'd1);
    localparam logic [WE_W-1:0]   WE_ONE    = WE_W'(32'd1);
    localparam logic [WE_W-1:0]   WE_THR    = WE_W'(LOSS_THR);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Next bit the generator would emit, given the last NUM_BITS bits.
    // h[1] is the most recent bit and h[NUM_BITS] the oldest.
    function automatic logic predict_bit(input logic [NUM_BITS:1] h);
        predict_bit = ~(h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D]);
    endfunction

    // Add one, but hold at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 1'b1;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_BITS:1] hist_r;
    logic [FILL_W-1:0] fill_r;
    state_t            state_r;
    logic [MR_W-1:0]   match_run_r;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [WE_W-1:0]   win_err_r;

    // Combinational helpers
    logic [NUM_BITS:1] hist_next_s;
    logic              pred_s;
    logic              valid_s;
    logic              mismatch_s;
    logic              hist_ones_s;
    logic              win_wrap_s;
    logic [WE_W-1:0]   win_err_next_s;
    logic [MR_W-1:0]   match_next_s;

    // Prediction, mismatch detection and next values for the hunt/window counters
    always_comb begin
        hist_next_s = {hist_r[NUM_BITS-1:1], i_bit};
        pred_s      = predict_bit(hist_r);
        valid_s     = (fill_r == FILL_FULL);
        mismatch_s  = valid_s & (i_bit != pred_s);
        hist_ones_s = &hist_r;
        win_wrap_s  = (win_cnt_r == WIN_LAST);

        // At a window boundary the count restarts. The current bit still
        // counts if it is wrong.
        if (win_wrap_s) begin
            win_err_next_s = mismatch_s ? WE_ONE : {WE_W{1'b0}};
        end else begin
            win_err_next_s = win_err_r + WE_W'(mismatch_s);
        end

        // An all-ones history is the XNOR lock-up pattern. It predicts itself
        // forever, so it must never build up a lock run.
        if (hist_ones_s || mismatch_s) begin
            match_next_s = {MR_W{1'b0}};
        end else begin
            match_next_s = match_run_r + 1'b1;
        end
    end

    // History shift register and registered lock-up flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r   <= {NUM_BITS{1'b0}};
            o_lockup <= 1'b0;
        end else if (enable) begin
            hist_r   <= hist_next_s;
            o_lockup <= &hist_next_s;
        end
    end

    // Fill counter: counts enabled bits up to NUM_BITS, then holds.
    // Only reset clears it, so loss of lock never forces a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_r <= {FILL_W{1'b0}};
        end else if (enable && (fill_r != FILL_FULL)) begin
            fill_r <= fill_r + 1'b1;
        end
    end

    // HUNT/LOCKED state machine with registered lock and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_HUNT;
            match_run_r <= {MR_W{1'b0}};
            win_cnt_r   <= {WIN_W{1'b0}};
            win_err_r   <= {WE_W{1'b0}};
            o_locked    <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_error <= 1'b0;
            if (enable) begin
                case (state_r)
                    ST_HUNT: begin
                        if (valid_s) begin
                            if (match_next_s == LOCK_RUN) begin
                                state_r     <= ST_LOCKED;
                                o_locked    <= 1'b1;
                                match_run_r <= {MR_W{1'b0}};
                                win_cnt_r   <= {WIN_W{1'b0}};
                                win_err_r   <= {WE_W{1'b0}};
                            end else begin
                                match_run_r <= match_next_s;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        o_error <= mismatch_s;
                        if (win_err_next_s == WE_THR) begin
                            state_r     <= ST_HUNT;
                            o_locked    <= 1'b0;
                            match_run_r <= {MR_W{1'b0}};
                            win_cnt_r   <= {WIN_W{1'b0}};
                            win_err_r   <= {WE_W{1'b0}};
                        end else begin
                            win_cnt_r <= win_wrap_s ? {WIN_W{1'b0}} : (win_cnt_r + 1'b1);
                            win_err_r <= win_err_next_s;
                        end
                    end
                    default: begin
                        state_r     <= ST_HUNT;
                        o_locked    <= 1'b0;
                        match_run_r <= {MR_W{1'b0}};
                        win_cnt_r   <= {WIN_W{1'b0}};
                        win_err_r   <= {WE_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Saturating bit/error counters. A clear request wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_bit_count <= {CNT_W{1'b0}};
            o_err_count <= {CNT_W{1'b0}};
        end else if (i_clear_cnt) begin
            o_bit_count <= {CNT_W{1'b0}};
            o_err_count <= {CNT_W{1'b0}};
        end else if (enable && (state_r == ST_LOCKED)) begin
            o_bit_count <= sat_inc(o_bit_count);
            if (mismatch_s) begin
                o_err_count <= sat_inc(o_err_count);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker (NUM_BITS = 32).
// A second instance with CNT_W = 4 shares the same inputs so that counter
// saturation can be seen with short runs.

module tb_prbs_checker;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        i_bit;
    logic        i_clear_cnt;
    logic        o_locked;
    logic        o_error;
    logic        o_lockup;
    logic [31:0] o_err_count;
    logic [31:0] o_bit_count;
    logic        s_locked;
    logic        s_error;
    logic        s_lockup;
    logic [3:0]  s_err_count;
    logic [3:0]  s_bit_count;

    int checks;
    int errors;
    int nbits;
    logic [32:1] gen_r;

    prbs_checker #(.NUM_BITS(32), .LOCK_CNT(64), .LOSS_WIN(256), .LOSS_THR(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_bit(i_bit), .i_clear_cnt(i_clear_cnt),
        .o_locked(o_locked), .o_error(o_error), .o_lockup(o_lockup),
        .o_err_count(o_err_count), .o_bit_count(o_bit_count)
    );

    prbs_checker #(.NUM_BITS(32), .LOCK_CNT(64), .LOSS_WIN(256), .LOSS_THR(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .i_bit(i_bit), .i_clear_cnt(i_clear_cnt),
        .o_locked(s_locked), .o_error(s_error), .o_lockup(s_lockup),
        .o_err_count(s_err_count), .o_bit_count(s_bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference XNOR Fibonacci generator, taps 32,22,2,1.
    task automatic gen_bit(output logic b);
        b = ~(gen_r[32] ^ gen_r[22] ^ gen_r[2] ^ gen_r[1]);
        gen_r = {gen_r[31:1], b};
    endtask

    // One clock: enabled clocks take the next generator bit (optionally
    // inverted), disabled clocks drive a random junk bit.
    task automatic tick(input logic en, input logic flip, input logic clr);
        logic b;
        if (en) begin
            gen_bit(b);
            i_bit = b ^ flip;
            nbits++;
        end else begin
            i_bit = 1'($urandom_range(1, 0));
        end
        enable      = en;
        i_clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic en;
        logic din;
        logic clr;
        logic exp_lockup;
        logic exp_locked;
        logic exp_error;
    } vec_t;

    vec_t vecs[106];

    initial begin
        int pulses;
        int hunt_pulses;
        int loss_j;
        int base_bits;
        logic en;
        logic flip;

        checks = 0;
        errors = 0;

        // Constant-ones vectors: lock-up shows after the 32nd enabled one;
        // enable-low clocks hold; lock never happens; a zero clears lock-up.
        for (int i = 0; i < 31; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[31] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[32] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[33] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[34] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 35; i < 105; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[105] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst         = 1'b1;
        enable      = 1'b0;
        i_bit       = 1'b0;
        i_clear_cnt = 1'b0;
        gen_r       = 32'h0000_0001;
        nbits       = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_locked", {31'd0, o_locked}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        check("rst_lockup", {31'd0, o_lockup}, 32'd0);
        check("rst_err_count", o_err_count, 32'd0);
        check("rst_bit_count", o_bit_count, 32'd0);
        rst = 1'b0;

        // Clean stream: lock on enabled bit 96 (32 fill + 64 matches)
        pulses = 0;
        for (int i = 1; i <= 96; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (o_error) pulses++;
            if (i == 95) check("lock_not_before_96", {31'd0, o_locked}, 32'd0);
            if (i == 96) check("lock_at_96", {31'd0, o_locked}, 32'd1);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (o_error) pulses++;
        end
        check("clean_error_pulses", pulses, 32'd0);
        check("clean_err_count", o_err_count, 32'd0);
        check("clean_bit_count", o_bit_count, nbits - 96);
        check("sat_bit_count_hold", {28'd0, s_bit_count}, 32'hF);
        check("sat_locked", {31'd0, s_locked}, 32'd1);

        // Single inverted bit: errors at offsets 0, 1, 2, 22, 32
        base_bits = nbits;
        for (int j = 0; j < 40; j++) begin
            tick(1'b1, (j == 0), 1'b0);
            check($sformatf("single_flip_error_j%0d", j), {31'd0, o_error},
                  ((j == 0) || (j == 1) || (j == 2) || (j == 22) || (j == 32)) ? 32'd1 : 32'd0);
        end
        check("single_flip_err_count", o_err_count, 32'd5);
        check("single_flip_locked", {31'd0, o_locked}, 32'd1);
        check("single_flip_bit_count", o_bit_count, nbits - 96);
        check("sat_err_count_5", {28'd0, s_err_count}, 32'd5);

        // Clear on the same cycle as a mismatching bit
        tick(1'b1, 1'b1, 1'b1);
        check("clear_err_count", o_err_count, 32'd0);
        check("clear_bit_count", o_bit_count, 32'd0);
        check("clear_error_pulse", {31'd0, o_error}, 32'd1);
        for (int j = 1; j <= 32; j++) tick(1'b1, 1'b0, 1'b0);
        check("after_clear_err_count", o_err_count, 32'd4);
        check("after_clear_bit_count", o_bit_count, 32'd32);
        check("sat_bit_after_clear", {28'd0, s_bit_count}, 32'hF);
        check("sat_err_after_clear", {28'd0, s_err_count}, 32'd4);

        // Enable low holds everything; clear still acts
        for (int j = 0; j < 3; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            check("hold_error", {31'd0, o_error}, 32'd0);
            check("hold_bit_count", o_bit_count, 32'd32);
            check("hold_locked", {31'd0, o_locked}, 32'd1);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("clear_disabled_err", o_err_count, 32'd0);
        check("clear_disabled_bits", o_bit_count, 32'd0);

        // Asynchronous reset while locked
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_locked", {31'd0, o_locked}, 32'd0);
        check("async_rst_error", {31'd0, o_error}, 32'd0);
        check("async_rst_lockup", {31'd0, o_lockup}, 32'd0);
        check("async_rst_err_count", o_err_count, 32'd0);
        check("async_rst_bit_count", o_bit_count, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        gen_r = 32'h0000_0001;
        nbits = 0;

        // Re-lock with enable toggling: needs 96 enabled bits again
        for (int c = 0; c < 400; c++) begin
            en = (c % 2 == 0);
            tick(en, 1'b0, 1'b0);
            if (!en) check("toggle_error_low", {31'd0, o_error}, 32'd0);
            if (en && (nbits == 95)) check("toggle_no_lock_95", {31'd0, o_locked}, 32'd0);
            if (en && (nbits == 96)) begin
                check("toggle_lock_96", {31'd0, o_locked}, 32'd1);
                break;
            end
        end
        check("toggle_enabled_bits", nbits, 32'd96);

        // Every 8th bit inverted from the first locked bit. Error positions
        // 0,1,2,8,9,10,16,17,18,22,24,25,26,30,33,34: the 16th is at 34.
        // Flips stop after loss; the last flip is at 32, the last mismatch at
        // 64, so 64 matches re-lock at 128 with no refill.
        pulses      = 0;
        hunt_pulses = 0;
        loss_j      = -1;
        for (int j = 0; j < 200; j++) begin
            flip = (loss_j < 0) && (j % 8 == 0);
            tick(1'b1, flip, 1'b0);
            if (loss_j < 0) begin
                if (o_error) pulses++;
                if (!o_locked) begin
                    loss_j = j;
                    check("loss_error_pulse", {31'd0, o_error}, 32'd1);
                end
            end else begin
                if (o_error) hunt_pulses++;
                if (j == 127) check("relock_not_before", {31'd0, o_locked}, 32'd0);
                if (j == 128) begin
                    check("relock_at_128", {31'd0, o_locked}, 32'd1);
                    break;
                end
            end
        end
        check("loss_index", loss_j, 32'd34);
        check("loss_pulses", pulses, 32'd16);
        check("hunt_no_error", hunt_pulses, 32'd0);
        check("loss_err_count", o_err_count, 32'd16);
        check("loss_bit_count", o_bit_count, 32'd35);
        check("sat_err_count_F", {28'd0, s_err_count}, 32'hF);

        // Constant ones from reset: lock-up flag, never locks, never errors
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 106; i++) begin
            enable      = vecs[i].en;
            i_bit       = vecs[i].din;
            i_clear_cnt = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_lockup", i), {31'd0, o_lockup}, {31'd0, vecs[i].exp_lockup});
            check($sformatf("vec%0d_locked", i), {31'd0, o_locked}, {31'd0, vecs[i].exp_locked});
            check($sformatf("vec%0d_error", i), {31'd0, o_error}, {31'd0, vecs[i].exp_error});
        end
        check("ones_err_count", o_err_count, 32'd0);
        check("ones_bit_count", o_bit_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
